// File: rtl/router_pkg.sv
// Shared definitions for the 1x3 packet router: data width, header field layout
// and the FIFO entry format (header flag beside the data byte).
package router_pkg;
  localparam int DATA_W    = 8;
  localparam int DEPTH     = 16;
  localparam int ADDR_W    = 4;
  localparam int LEN_MSB   = 7;
  localparam int LEN_LSB   = 2;
  localparam int ADDR_MSB  = 1;
  localparam int ADDR_LSB  = 0;
  localparam int ENTRY_W   = DATA_W + 1;
  localparam int LEN_CNT_W = 7;

  typedef struct packed {
    logic              hdr;
    logic [DATA_W-1:0] data;
  } entry_t;

  // Bytes still to come after a header: payload length plus the parity byte.
  function automatic logic [LEN_CNT_W-1:0] hdr_len(input logic [DATA_W-1:0] hdr);
    return LEN_CNT_W'(hdr[LEN_MSB:LEN_LSB]) + 7'd1;
  endfunction
endpackage

// File: rtl/router_fifo_if.sv
// Write/read bus of one router output FIFO. A write or read request is accepted
// on a rising clk edge only when its enable is high and full (resp. empty) is low.
interface router_fifo_if;
  import router_pkg::*;

  logic              write_enb;
  logic              lfd_state;
  logic [DATA_W-1:0] din;
  logic              read_enb;
  logic [DATA_W-1:0] dout;
  logic              full;
  logic              empty;
  logic              pkt_busy;
  logic              pkt_done;

  modport master (
    output write_enb, lfd_state, din, read_enb,
    input  dout, full, empty, pkt_busy, pkt_done
  );

  modport slave (
    input  write_enb, lfd_state, din, read_enb,
    output dout, full, empty, pkt_busy, pkt_done
  );
endinterface

// File: rtl/router_fifo_ram.sv
// Entry storage: one write port, one registered read port (cleared by reset or
// flush) and an unregistered view of the entry at the read address.
module router_fifo_ram
  import router_pkg::*;
#(
  parameter int DEPTH  = router_pkg::DEPTH,
  parameter int ADDR_W = router_pkg::ADDR_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clr,
  input  logic              we,
  input  logic [ADDR_W-1:0] wr_addr,
  input  entry_t            wr_entry,
  input  logic              re,
  input  logic [ADDR_W-1:0] rd_addr,
  output entry_t            rd_peek,
  output logic [DATA_W-1:0] rd_data
);
  entry_t mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[wr_addr] <= wr_entry;
  end

  assign rd_peek = mem[rd_addr];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)     rd_data <= '0;
    else if (clr) rd_data <= '0;
    else if (re)  rd_data <= mem[rd_addr].data;
  end
endmodule

// File: rtl/router_fifo.sv
// Per-port output FIFO of the packet router: pointer/flag bookkeeping plus a
// read-side length counter that marks where each packet ends.
module router_fifo
  import router_pkg::*;
#(
  parameter int DEPTH  = router_pkg::DEPTH,
  parameter int ADDR_W = router_pkg::ADDR_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             soft_rst,
  router_fifo_if.slave     bus
);
  logic [ADDR_W:0]    wr_ptr, rd_ptr;
  logic [LEN_CNT_W-1:0] len_cnt, len_nxt;
  logic               done_q, done_nxt;
  logic               full, empty;
  logic               wr_fire, rd_fire;
  entry_t             rd_peek;
  entry_t             wr_entry;

  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[ADDR_W-1:0] == rd_ptr[ADDR_W-1:0]) &&
                 (wr_ptr[ADDR_W] != rd_ptr[ADDR_W]);

  // A flush wins over any access requested in the same cycle.
  assign wr_fire = bus.write_enb && !full  && !soft_rst;
  assign rd_fire = bus.read_enb  && !empty && !soft_rst;

  assign wr_entry = '{hdr: bus.lfd_state, data: bus.din};

  router_fifo_ram #(.DEPTH(DEPTH), .ADDR_W(ADDR_W)) u_ram (
    .clk      (clk),
    .rst      (rst),
    .clr      (soft_rst),
    .we       (wr_fire),
    .wr_addr  (wr_ptr[ADDR_W-1:0]),
    .wr_entry (wr_entry),
    .re       (rd_fire),
    .rd_addr  (rd_ptr[ADDR_W-1:0]),
    .rd_peek  (rd_peek),
    .rd_data  (bus.dout)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else if (soft_rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (wr_fire) wr_ptr <= wr_ptr + 1'b1;
      if (rd_fire) rd_ptr <= rd_ptr + 1'b1;
    end
  end

  // A header always reloads the count, so a truncated packet ends silently.
  always_comb begin
    len_nxt  = len_cnt;
    done_nxt = 1'b0;
    if (rd_fire) begin
      if (rd_peek.hdr) begin
        len_nxt = hdr_len(rd_peek.data);
      end else if (len_cnt != '0) begin
        len_nxt  = len_cnt - 1'b1;
        done_nxt = (len_cnt == LEN_CNT_W'(1));
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      len_cnt <= '0;
      done_q  <= 1'b0;
    end else if (soft_rst) begin
      len_cnt <= '0;
      done_q  <= 1'b0;
    end else begin
      len_cnt <= len_nxt;
      done_q  <= done_nxt;
    end
  end

  assign bus.full     = full;
  assign bus.empty    = empty;
  assign bus.pkt_busy = (len_cnt != '0);
  assign bus.pkt_done = done_q;
endmodule

// File: tb/tb_router_fifo.sv
// Random and directed stimulus for router_fifo, checked every cycle against a
// queue-based model of the FIFO and its packet-length bookkeeping.
module tb_router_fifo;
  logic clk = 1'b0;
  logic rst;
  logic soft_rst;

  router_fifo_if bus ();

  router_fifo dut (
    .clk      (clk),
    .rst      (rst),
    .soft_rst (soft_rst),
    .bus      (bus)
  );

  always #5 clk = ~clk;

  // Reference model: stored entries as {hdr, data}, plus expected outputs.
  logic [8:0] exp_q[$];
  logic [7:0] m_dout;
  int         m_len;
  logic       m_done;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic check_outputs(input string tag);
    check({tag, ".dout"},     32'(bus.dout),     32'(m_dout));
    check({tag, ".full"},     32'(bus.full),     32'(exp_q.size() == 16));
    check({tag, ".empty"},    32'(bus.empty),    32'(exp_q.size() == 0));
    check({tag, ".pkt_busy"}, 32'(bus.pkt_busy), 32'(m_len != 0));
    check({tag, ".pkt_done"}, 32'(bus.pkt_done), 32'(m_done));
  endtask

  task automatic model_reset();
    exp_q.delete();
    m_dout = 8'h00;
    m_len  = 0;
    m_done = 1'b0;
  endtask

  task automatic model_step(input logic we, lfd, input logic [7:0] d, input logic re, srst);
    logic [8:0] e;
    bit do_w, do_r;
    if (srst) begin
      model_reset();
      return;
    end
    do_w   = we && (exp_q.size() < 16);
    do_r   = re && (exp_q.size() > 0);
    m_done = 1'b0;
    if (do_r) begin
      e      = exp_q.pop_front();
      m_dout = e[7:0];
      if (e[8]) begin
        m_len = int'(e[7:2]) + 1;
      end else if (m_len > 0) begin
        if (m_len == 1) m_done = 1'b1;
        m_len = m_len - 1;
      end
    end
    if (do_w) exp_q.push_back({lfd, d});
  endtask

  // Drive one cycle's inputs, advance the model at the edge, check just after it.
  task automatic cycle(input string tag, input logic we, lfd, input logic [7:0] d,
                       input logic re, srst);
    bus.write_enb = we;
    bus.lfd_state = lfd;
    bus.din       = d;
    bus.read_enb  = re;
    soft_rst      = srst;
    @(posedge clk);
    model_step(we, lfd, d, re, srst);
    #1;
    check_outputs(tag);
  endtask

  initial begin
    rst           = 1'b0;
    soft_rst      = 1'b0;
    bus.write_enb = 1'b0;
    bus.lfd_state = 1'b0;
    bus.din       = 8'h00;
    bus.read_enb  = 1'b0;
    model_reset();
    #12;
    check_outputs("por");
    rst = 1'b1;

    // 1: asynchronous reset in the middle of a packet
    cycle("t1_hdr", 1, 1, 8'h09, 0, 0);
    cycle("t1_pay", 1, 0, 8'h44, 0, 0);
    cycle("t1_rd",  0, 0, 8'h00, 1, 0);
    rst = 1'b0;
    #1;
    model_reset();
    check_outputs("t1_async_rst");
    #2 rst = 1'b1;

    // 2: fill to full, overflow write dropped, drain in order
    for (int i = 1; i <= 16; i++) cycle("t2_fill", 1, 0, 8'(i), 0, 0);
    check("t2_full", 32'(bus.full), 32'd1);
    cycle("t2_ovf", 1, 0, 8'hAA, 0, 0);
    cycle("t2_ovf_rw", 1, 0, 8'hAB, 1, 0);
    check("t2_first", 32'(bus.dout), 32'h01);
    for (int i = 2; i <= 16; i++) cycle("t2_drain", 0, 0, 8'h00, 1, 0);
    check("t2_last", 32'(bus.dout), 32'h10);
    check("t2_empty", 32'(bus.empty), 32'd1);

    // 3: one complete packet, length 3
    cycle("t3_w", 1, 1, 8'h0D, 0, 0);
    cycle("t3_w", 1, 0, 8'h11, 0, 0);
    cycle("t3_w", 1, 0, 8'h22, 0, 0);
    cycle("t3_w", 1, 0, 8'h33, 0, 0);
    cycle("t3_w", 1, 0, 8'h3D, 0, 0);
    for (int i = 0; i < 5; i++) cycle("t3_r", 0, 0, 8'h00, 1, 0);
    check("t3_parity", 32'(bus.dout), 32'h3D);
    check("t3_done", 32'(bus.pkt_done), 32'd1);
    cycle("t3_idle", 0, 0, 8'h00, 0, 0);

    // 4: steady read+write at occupancy 8 across the pointer wrap
    for (int i = 0; i < 8; i++) cycle("t4_pre", 1, 0, 8'($urandom_range(0, 255)), 0, 0);
    for (int i = 0; i < 20; i++) cycle("t4_rw", 1, 0, 8'($urandom_range(0, 255)), 1, 0);
    check("t4_occ", 32'(exp_q.size()), 32'd8);
    for (int i = 0; i < 8; i++) cycle("t4_drain", 0, 0, 8'h00, 1, 0);

    // 5: flush with both requests high
    for (int i = 0; i < 5; i++) cycle("t5_pre", 1, (i == 0), 8'(8'h30 + i), 0, 0);
    cycle("t5_hdr_rd", 0, 0, 8'h00, 1, 0);
    cycle("t5_srst", 1, 0, 8'h55, 1, 1);
    check("t5_dout0", 32'(bus.dout), 32'h00);
    cycle("t5_after", 0, 0, 8'h00, 1, 0);

    // 6: read on empty holds dout; zero-length packet
    cycle("t6_w", 1, 0, 8'h77, 0, 0);
    cycle("t6_r", 0, 0, 8'h00, 1, 0);
    cycle("t6_rempty", 0, 0, 8'h00, 1, 0);
    check("t6_hold", 32'(bus.dout), 32'h77);
    cycle("t6_hdr0", 1, 1, 8'h00, 0, 0);
    cycle("t6_par", 1, 0, 8'h5A, 0, 0);
    cycle("t6_r1", 0, 0, 8'h00, 1, 0);
    check("t6_busy", 32'(bus.pkt_busy), 32'd1);
    cycle("t6_r2", 0, 0, 8'h00, 1, 0);
    check("t6_done", 32'(bus.pkt_done), 32'd1);

    // Random traffic, including headers and occasional flushes
    for (int i = 0; i < 600; i++) begin
      cycle("rand",
            1'($urandom_range(0, 1)),
            1'($urandom_range(0, 5) == 0),
            8'($urandom_range(0, 255)),
            1'($urandom_range(0, 99) < 55),
            1'($urandom_range(0, 63) == 0));
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
